// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: A/Q/Qm1/M registers, ALU and
// iteration counter, steered by the 6-bit control vector CV.
module booth_datapath #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [5:0]     CV,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           Q1,
   output logic           Q0,
   output logic           count,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   // A and M carry a guard bit so subtracting M = -2^(N-1) cannot overflow
   logic [N:0]    a;
   logic [N-1:0]  q;
   logic          qm1;
   logic [N:0]    m;
   logic [CW-1:0] cnt;
   logic [N:0]    alu;
   logic [N:0]    a_src;

   // ALU: subtract has priority over add, otherwise pass A through
   always_comb begin
      alu = a;
      if (CV[3]) begin
         alu = a - m;
      end else if (CV[4]) begin
         alu = a + m;
      end
   end

   // value fed to A or to the shifter: ALU result when loading, else A
   always_comb begin
      a_src = CV[2] ? alu : a;
   end

   // register update: reset, then init, then load/shift/decrement
   always_ff @(posedge clk) begin
      if (rst) begin
         a   <= '0;
         q   <= '0;
         qm1 <= 1'b0;
         m   <= '0;
         cnt <= '0;
      end else if (CV[5]) begin
         a   <= '0;
         q   <= multiplier;
         qm1 <= 1'b0;
         m   <= {multiplicand[N-1], multiplicand};
         cnt <= CW'(N);
      end else begin
         if (CV[1]) begin
            {a, q, qm1} <= {a_src[N], a_src, q};
         end else begin
            a <= a_src;
         end
         if (CV[0] && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign Q1      = q[0];
   assign Q0      = qm1;
   assign count   = (cnt == '0);
   assign product = {a[N-1:0], q};

endmodule

// File: tb/tb_booth_datapath.sv
// Bench for booth_datapath: drives CV on the falling edge like the control
// unit, checks results against signed arithmetic and a value-level model.
module tb_booth_datapath;

   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic [5:0]     cv;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           q1;
   logic           q0;
   logic           count;
   logic [2*N-1:0] product;

   int total = 0;
   int bad   = 0;

   // model state as plain signed/unsigned integers
   int ma, mq, mqm1, mm, mcnt;

   booth_datapath #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .CV           (cv),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .Q1           (q1),
      .Q0           (q0),
      .count        (count),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wrapa(input int x);
      int y;
      y = x & ((1 << (N + 1)) - 1);
      if (y >= (1 << N)) y = y - (1 << (N + 1));
      return y;
   endfunction

   function automatic void model_apply(input logic [5:0] c, input logic r);
      int alu;
      int v;
      if (r) begin
         ma = 0; mq = 0; mqm1 = 0; mm = 0; mcnt = 0;
      end else if (c[5]) begin
         ma   = 0;
         mq   = int'(multiplier);
         mqm1 = 0;
         mm   = int'($signed(multiplicand));
         mcnt = N;
      end else begin
         alu = ma;
         if (c[3]) alu = wrapa(ma - mm);
         else if (c[4]) alu = wrapa(ma + mm);
         if (c[2]) ma = alu;
         if (c[1]) begin
            v    = ma * (1 << (N + 1)) + mq * 2 + mqm1;
            v    = v >>> 1;
            mqm1 = v & 1;
            mq   = (v >>> 1) & ((1 << N) - 1);
            ma   = v >>> (N + 1);
         end
         if (c[0] && mcnt > 0) mcnt = mcnt - 1;
      end
   endfunction

   function automatic logic [2*N-1:0] model_product();
      int t;
      t = ((ma & ((1 << N) - 1)) << N) | mq;
      return t[2*N-1:0];
   endfunction

   function automatic logic [2*N-1:0] signed_mul(input logic [N-1:0] x,
                                                 input logic [N-1:0] y);
      int s;
      s = int'($signed(x)) * int'($signed(y));
      return s[2*N-1:0];
   endfunction

   task automatic step(input logic [5:0] c, input logic r);
      @(negedge clk);
      cv  = c;
      rst = r;
      @(posedge clk);
      #1;
      model_apply(c, r);
   endtask

   task automatic iterate();
      if ({q1, q0} == 2'b10) step(6'h0C, 1'b0);
      else if ({q1, q0} == 2'b01) step(6'h14, 1'b0);
      step(6'h02, 1'b0);
      step(6'h01, 1'b0);
   endtask

   task automatic run_partial(input logic [N-1:0] mc, input logic [N-1:0] mp,
                              input int k);
      multiplicand = mc;
      multiplier   = mp;
      step(6'h20, 1'b0);
      for (int i = 0; i < k; i++) iterate();
   endtask

   task automatic run_mult(input logic [N-1:0] mc, input logic [N-1:0] mp,
                           output logic [2*N-1:0] prod, output int iters);
      multiplicand = mc;
      multiplier   = mp;
      step(6'h20, 1'b0);
      iters = 0;
      while (count !== 1'b1 && iters < 2 * N + 2) begin
         iterate();
         iters++;
      end
      prod = product;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cv  = 6'h3F;
      multiplicand = 4'h7;
      multiplier   = 4'h7;
      @(posedge clk);
      #1;
      model_apply(6'h3F, 1'b1);
      total++;
      if (product !== 8'h00) begin
         bad++; $display("FAIL reset_product got=%h want=00", product);
      end
      total++;
      if ({q1, q0, count} !== 3'b001) begin
         bad++; $display("FAIL reset_status got=%b want=001", {q1, q0, count});
      end
      step(6'h3F, 1'b1);
      total++;
      if ({product, q1, q0, count} !== {8'h00, 3'b001}) begin
         bad++;
         $display("FAIL reset_hold got=%h/%b want=00/001", product,
                  {q1, q0, count});
      end
   endtask

   task automatic test_runs();
      logic [N-1:0]   mcs [4] = '{4'h3, 4'h8, 4'h7, 4'h0};
      logic [N-1:0]   mps [4] = '{4'hE, 4'h8, 4'h7, 4'hB};
      logic [2*N-1:0] want[4] = '{8'hFA, 8'h40, 8'h31, 8'h00};
      logic [2*N-1:0] p;
      int it;
      for (int i = 0; i < 4; i++) begin
         run_mult(mcs[i], mps[i], p, it);
         total++;
         if (it !== N) begin
            bad++; $display("FAIL run_iters[%0d] got=%0d want=%0d", i, it, N);
         end
         total++;
         if (p !== want[i]) begin
            bad++; $display("FAIL run_product[%0d] got=%h want=%h", i, p, want[i]);
         end
      end
   endtask

   task automatic test_random_runs();
      logic [N-1:0] mc, mp;
      logic [2*N-1:0] p, e;
      int it;
      for (int i = 0; i < 12; i++) begin
         mc = N'($urandom);
         mp = N'($urandom);
         run_mult(mc, mp, p, it);
         e = signed_mul(mc, mp);
         total++;
         if (p !== e || it !== N) begin
            bad++;
            $display("FAIL rand_run %h*%h got=%h/%0d want=%h/%0d",
                     mc, mp, p, it, e, N);
         end
      end
   endtask

   task automatic test_direct_cv();
      multiplicand = 4'h3;
      multiplier   = 4'h5;
      step(6'h20, 1'b0);
      step(6'h14, 1'b0);
      total++;
      if (product !== 8'h35) begin
         bad++; $display("FAIL cv_add got=%h want=35", product);
      end
      step(6'h02, 1'b0);
      total++;
      if (product !== 8'h1A || {q1, q0} !== 2'b01) begin
         bad++;
         $display("FAIL cv_shift got=%h/%b want=1A/01", product, {q1, q0});
      end
      step(6'h0C, 1'b0);
      total++;
      if (product !== 8'hEA || product !== model_product()) begin
         bad++; $display("FAIL cv_sub got=%h want=EA", product);
      end
   endtask

   task automatic test_saturation();
      logic [2*N-1:0] p;
      int it;
      run_mult(4'h2, 4'h3, p, it);
      for (int i = 0; i < 3; i++) begin
         step(6'h01, 1'b0);
         total++;
         if (count !== 1'b1 || product !== 8'h06) begin
            bad++;
            $display("FAIL sat[%0d] got=%b/%h want=1/06", i, count, product);
         end
      end
   endtask

   task automatic test_abort();
      logic [2*N-1:0] p;
      int it;
      run_partial(4'h6, 4'h7, 2);
      step(6'h00, 1'b1);
      total++;
      if ({product, q1, q0, count} !== {8'h00, 3'b001}) begin
         bad++;
         $display("FAIL abort_rst got=%h/%b want=00/001", product,
                  {q1, q0, count});
      end
      run_mult(4'h5, 4'hD, p, it);
      total++;
      if (p !== 8'hF1 || it !== N) begin
         bad++; $display("FAIL abort_rerun got=%h/%0d want=F1/%0d", p, it, N);
      end
      run_partial(4'h6, 4'h7, 2);
      run_mult(4'hC, 4'h5, p, it);
      total++;
      if (p !== 8'hEC || it !== N) begin
         bad++; $display("FAIL reinit got=%h/%0d want=EC/%0d", p, it, N);
      end
   endtask

   task automatic test_random_cv();
      logic [5:0] c;
      logic r;
      logic [2*N-1:0] e;
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      step(6'h20, 1'b0);
      for (int i = 0; i < 80; i++) begin
         c = 6'($urandom);
         if ($urandom_range(0, 7) != 0) c[5] = 1'b0;
         r = ($urandom_range(0, 24) == 0);
         multiplicand = N'($urandom);
         multiplier   = N'($urandom);
         step(c, r);
         e = model_product();
         total++;
         if (product !== e) begin
            bad++; $display("FAIL rcv_product[%0d] cv=%h got=%h want=%h",
                            i, c, product, e);
         end
         total++;
         if ({q1, q0, count} !== {mq[0], mqm1[0], mcnt == 0}) begin
            bad++; $display("FAIL rcv_status[%0d] cv=%h got=%b want=%b", i, c,
                            {q1, q0, count}, {mq[0], mqm1[0], mcnt == 0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_runs();
      test_random_runs();
      test_direct_cv();
      test_saturation();
      test_abort();
      test_random_cv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Radix-2 Booth multiplier datapath. It is the execute end of the 6-bit control-vector interface driven by the Booth control unit.
- It consumes CV each cycle, performs init, add, subtract, shift and count operations, and returns the status bits Q1, Q0 and count that steer the control unit.
- The product is exposed continuously. The control unit's done flag marks it valid.

Parameters:
N, 4, operand width in bits (two's complement). Legal range 2..16.
CW, $clog2(N+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock. All datapath registers update on the rising edge. The control unit updates on the falling edge, so CV is stable at each rising edge.
rst  input  1  synchronous active-high reset.
CV  input  6  control vector:
  - [5] init
  - [4] ALU add
  - [3] ALU subtract
  - [2] load A from ALU
  - [1] arithmetic shift right
  - [0] decrement counter
multiplicand  input  N  M operand, sampled only on init.
multiplier  input  N  Q operand, sampled only on init.
Q1  output  1  Q[0], current multiplier LSB.
Q0  output  1  Q_-1, extra Booth bit.
count  output  1  high when counter == 0 (combinational from register).
product  output  2N  {A[N-1:0], Q}.

Behaviour:
- Registers:
  - A: N+1 bits, so the extra guard bit absorbs overflow when subtracting M = -2^(N-1).
  - Q: N bits.
  - Qm1: 1 bit.
  - M: N+1 bits, sign-extended.
  - cnt: CW bits.
- Reset, applied at the rising edge with rst=1:
  - A, Q, Qm1, M, cnt all cleared to 0.
  - Hence Q1=0, Q0=0, count=1, product=0.
  - rst overrides CV. Reset mid-multiply aborts cleanly, with no partial state retained.
- ALU (combinational, N+1 bits, modulo 2^(N+1)):
  - CV[3]=1: A - M. Subtract wins if CV[4] and CV[3] are both set.
  - CV[4]=1, CV[3]=0: A + M.
  - Neither set: pass A.
- Priority per rising edge, when rst=0:
  1. CV[5] init:
     - A <= 0.
     - Q <= multiplier.
     - Qm1 <= 0.
     - M <= sign-extended multiplicand.
     - cnt <= N.
     - All other CV bits are ignored in that cycle.
  2. Otherwise, the following apply in the same edge:
     - CV[2] and CV[1] together: A is loaded from ALU and the shift applies to the ALU result (load-then-shift). That is, {A,Q,Qm1} <= asr({ALU,Q,Qm1}).
     - CV[2] alone: A <= ALU.
     - CV[1] alone: {A,Q,Qm1} <= arithmetic right shift by one. A[N] is replicated, A[0] goes to Q[N-1], and Q[0] goes to Qm1.
     - CV[0]: cnt <= cnt - 1 if cnt != 0; it saturates at 0 and never wraps.
     - Independent bits combine freely.
  3. CV = 0: hold all registers.
- Latency: every operation completes in exactly one rising edge. Status outputs reflect it before the next falling edge.
- Handshake with the control unit:
  - Sequence per iteration: test, then optional add/sub plus load, then shift, then decrement.
  - N iterations after init bring cnt to 0.
  - count rises in the same half-cycle as the final decrement, so the control unit sees it at its next falling edge.
- Operand changes outside init have no effect.
- The product is only meaningful once count=1 after a completed run. Between init and completion it shows partial state; this is not an error.
- Re-init without reset is legal. An init during a run restarts cleanly.

Test Plan:
1. Reset: rst=1 for 2 cycles with CV=6'h3F -> product=0, Q1=0, Q0=0, count=1 after the first edge.
2. Full run with the control unit, N=4: multiplicand=4'h3, multiplier=4'hE (3 × -2) -> count rises after 4 decrements, product=8'hFA (-6).
3. Corner operand: -8 × -8 (4'h8, 4'h8) -> product=8'h40 (+64), proving the A guard bit. Also 7 × 7 -> 8'h31; 0 × -5 -> 8'h00.
4. Direct CV drive:
   - After init with M=3, Q=5: CV=6'h14 (add plus load) -> A=3.
   - Then CV=6'h02 -> A=1, Q=4'hA, Qm1=1, giving Q1=0, Q0=1.
   - Then CV=6'h0C from A=1 -> A=N+1-bit 5'h1E.
5. Counter saturation: after count=1, apply CV=6'h01 three more times -> cnt stays 0 and count stays 1.
6. Abort and restart:
   - Assert rst for one cycle at iteration 2 -> all registers clear.
   - Re-init with 5 × -3 and complete -> product=8'hF1 (-15).
   - Separately, init mid-run with no rst -> result is unaffected by the aborted run.
